// File: rtl/image_ram_writer_pkg.sv
// Shared image geometry and writer state encoding. The display-side locator
// uses the same geometry constants, so pixels written here line up with its reads.
package image_ram_writer_pkg;

   localparam int IMG_W     = 100;  // product image width in pixels
   localparam int IMG_H     = 100;  // product image height in pixels
   localparam int IMG_NUM   = 12;   // valid image slots 0..IMG_NUM-1
   localparam int ADDR_W    = 17;   // image RAM address width
   localparam int PIX_CNT_W = 14;   // enough to count one image's pixels

   // Writer FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } wr_state_t;

endpackage

// File: rtl/image_ram_writer_rgb_byte_packer.sv
// Collects R,G,B bytes into one pixel. The pixel is presented for exactly one
// cycle, the cycle after its blue byte is accepted. A clear drops any partial
// pixel and takes priority over a byte offered in the same cycle.
module rgb_byte_packer #(
   parameter int R_WIDTH = 8,
   parameter int G_WIDTH = 8,
   parameter int B_WIDTH = 8
) (
   input  logic                                 CLK,
   input  logic                                 RST_N,
   input  logic                                 i_clear,
   input  logic                                 i_byte_valid,
   input  logic [7:0]                           i_byte,
   output logic                                 o_b_accept,
   output logic                                 o_pixel_valid,
   output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]   o_pixel
);

   logic [1:0]                          r_phase;
   logic [R_WIDTH-1:0]                  r_red;
   logic [G_WIDTH-1:0]                  r_green;
   logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]  r_pixel;
   logic                                r_pixel_valid;
   logic                                w_take;

   assign w_take        = i_byte_valid && !i_clear;
   assign o_b_accept    = w_take && (r_phase == 2'd2);
   assign o_pixel_valid = r_pixel_valid;
   assign o_pixel       = r_pixel;

   // Byte phase: 0=R, 1=G, 2=B, wrapping back to R
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_phase <= 2'd0;
      end else if (i_clear) begin
         r_phase <= 2'd0;
      end else if (i_byte_valid) begin
         r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
      end
   end

   // Hold red and green until the blue byte completes the pixel
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_red   <= '0;
         r_green <= '0;
      end else if (i_clear) begin
         r_red   <= '0;
         r_green <= '0;
      end else if (w_take) begin
         if (r_phase == 2'd0) r_red   <= i_byte[R_WIDTH-1:0];
         if (r_phase == 2'd1) r_green <= i_byte[G_WIDTH-1:0];
      end
   end

   // Assembled pixel; the data register holds its value between pixels
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pixel_valid <= 1'b0;
         r_pixel       <= '0;
      end else begin
         r_pixel_valid <= o_b_accept;
         if (o_b_accept) r_pixel <= {r_red, r_green, i_byte[B_WIDTH-1:0]};
      end
   end

endmodule

// File: rtl/image_ram_writer.sv
// Writes one streamed 100x100 RGB product image into the image RAM at
// ImageID*W*H + y*W + x, the layout the display path reads back.
//
// Byte handshake: a byte moves only in a cycle where rx_valid and rx_ready are
// both high; while rx_ready is low the source must hold rx_data and rx_valid.
// rx_ready depends on state only, never on rx_valid.
module image_ram_writer
   import image_ram_writer_pkg::*;
#(
   parameter int R_WIDTH            = 8,
   parameter int G_WIDTH            = 8,
   parameter int B_WIDTH            = 8,
   parameter int ROM_ADDR_BUS_WIDTH = ADDR_W,
   parameter int PRDCT_PIC_WIDTH    = IMG_W,
   parameter int PRDCT_PIC_HEIGHT   = IMG_H,
   parameter int NUM_IMAGES         = IMG_NUM
) (
   input  logic                                 CLK,
   input  logic                                 RST_N,
   input  logic                                 start,
   input  logic [3:0]                           image_id,
   input  logic                                 abort,
   input  logic [7:0]                           rx_data,
   input  logic                                 rx_valid,
   output logic                                 rx_ready,
   output logic [ROM_ADDR_BUS_WIDTH-1:0]        ram_addr,
   output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]   ram_data,
   output logic                                 ram_we,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 error,
   output logic [1:0]                           dbg_state
);

   localparam int PIX_PER_IMG = PRDCT_PIC_WIDTH * PRDCT_PIC_HEIGHT;
   localparam int PIX_W       = R_WIDTH + G_WIDTH + B_WIDTH;
   localparam logic [PIX_CNT_W-1:0]          LAST_PIX   = PIX_CNT_W'(PIX_PER_IMG - 1);
   localparam logic [ROM_ADDR_BUS_WIDTH-1:0] IMG_STRIDE = ROM_ADDR_BUS_WIDTH'(PIX_PER_IMG);

   wr_state_t                     r_state;
   wr_state_t                     w_next_state;
   logic [ROM_ADDR_BUS_WIDTH-1:0] r_base;
   logic [ROM_ADDR_BUS_WIDTH-1:0] r_addr;
   logic [PIX_CNT_W-1:0]          r_pix_cnt;
   logic                          r_error;

   logic                          w_id_ok;
   logic                          w_load_go;
   logic                          w_bad_start;
   logic                          w_abort_load;
   logic                          w_rx_ready;
   logic                          w_busy;
   logic                          w_done;
   logic                          w_accept;
   logic                          w_clear;
   logic                          w_b_accept;
   logic                          w_last_pix;
   logic                          w_pix_valid;
   logic [PIX_W-1:0]              w_pixel;

   // Start is only honoured from IDLE; a start during a load is ignored outright
   assign w_id_ok      = int'(image_id) < NUM_IMAGES;
   assign w_load_go    = (r_state == ST_IDLE) && start && w_id_ok;
   assign w_bad_start  = (r_state == ST_IDLE) && start && !w_id_ok;

   assign w_rx_ready   = (r_state == ST_LOAD);
   assign w_busy       = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
   assign w_done       = (r_state == ST_DONE);
   assign w_abort_load = abort && w_busy;
   assign w_accept     = rx_valid && w_rx_ready;
   assign w_clear      = w_load_go || w_abort_load;
   assign w_last_pix   = w_b_accept && (r_pix_cnt == LAST_PIX);

   rgb_byte_packer #(
      .R_WIDTH (R_WIDTH),
      .G_WIDTH (G_WIDTH),
      .B_WIDTH (B_WIDTH)
   ) u_packer (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .i_clear       (w_clear),
      .i_byte_valid  (w_accept),
      .i_byte        (rx_data),
      .o_b_accept    (w_b_accept),
      .o_pixel_valid (w_pix_valid),
      .o_pixel       (w_pixel)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // FSM next state; FLUSH exists so the last pixel's write lands before DONE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_load_go) w_next_state = ST_LOAD;
         ST_LOAD: begin
            if (abort)           w_next_state = ST_IDLE;
            else if (w_last_pix) w_next_state = ST_FLUSH;
         end
         ST_FLUSH: w_next_state = abort ? ST_IDLE : ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Image base captured at start; pixel counter advances with each blue byte
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_base    <= '0;
         r_pix_cnt <= '0;
      end else if (w_load_go) begin
         r_base    <= ROM_ADDR_BUS_WIDTH'(image_id) * IMG_STRIDE;
         r_pix_cnt <= '0;
      end else if (w_b_accept) begin
         r_pix_cnt <= r_pix_cnt + 1'b1;
      end
   end

   // Write address formed alongside the pixel so both appear on the same cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)          r_addr <= '0;
      else if (w_b_accept) r_addr <= r_base + ROM_ADDR_BUS_WIDTH'(r_pix_cnt);
   end

   // Sticky error: set by an out-of-range start, cleared by the next good one
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)           r_error <= 1'b0;
      else if (w_bad_start) r_error <= 1'b1;
      else if (w_load_go)   r_error <= 1'b0;
   end

   assign rx_ready  = w_rx_ready;
   assign busy      = w_busy;
   assign done      = w_done;
   assign error     = r_error;
   assign ram_we    = w_pix_valid;
   assign ram_data  = w_pixel;
   assign ram_addr  = r_addr;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_image_ram_writer.sv
// Bench for image_ram_writer: random image bytes are streamed in, a model
// derives each expected RAM write (cycle, address, pixel) from the image
// geometry, and a monitor compares every ram_we cycle against that queue.
module tb_image_ram_writer;
   import image_ram_writer_pkg::*;

   localparam int EW = 73;  // {cycle[31:0], addr[16:0], pixel[23:0]}

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  image_id = 4'd0;
   logic        abort = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [16:0] ram_addr;
   logic [23:0] ram_data;
   logic        ram_we;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  dbg_state;

   logic [7:0]    img [30000];
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   int            d0;

   // Clock and cycle counter
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   image_ram_writer dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (start),
      .image_id  (image_id),
      .abort     (abort),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_we    (ram_we),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .dbg_state (dbg_state)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write must match the oldest expected one
   always @(negedge CLK) begin
      if (RST_N) begin
         if (done) done_cnt++;
         if (ram_we) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, expected no write",
                        ram_addr, ram_data, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               if ({32'(cyc), ram_addr, ram_data} !== mon_e) begin
                  fails++;
                  $display("FAIL ram_write: got cycle %0d addr %0d data %h, expected cycle %0d addr %0d data %h",
                           cyc, ram_addr, ram_data, mon_e[72:41], mon_e[40:24], mon_e[23:0]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_start(input int id);
      image_id = 4'(id);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // Drive img[0..nbytes-1] into image id; pct = chance rx_valid is high per
   // cycle. Optionally pulses start (id 4) when byte busy_start_at is offered.
   task automatic stream(input int id, input int nbytes, input int pct, input int busy_start_at);
      int k = 0;
      int stall = 0;
      int p;
      bit pulsed = 1'b0;
      while (k < nbytes) begin
         rx_valid = ($urandom_range(1, 100) <= pct);
         rx_data  = img[k];
         if (k == busy_start_at && !pulsed) begin
            start    = 1'b1;
            image_id = 4'd4;
            pulsed   = 1'b1;
         end
         @(negedge CLK);
         if (rx_valid && rx_ready) begin
            if (k % 3 == 2) begin
               p = k / 3;
               exp_q.push_back({32'(cyc + 1),
                                17'(id * 10000 + (p / 100) * 100 + (p % 100)),
                                img[k-2], img[k-1], img[k]});
            end
            k++;
            stall = 0;
         end else if (rx_valid) begin
            stall++;
            if (stall > 20) begin
               tests++;
               fails++;
               $display("FAIL stream_stall: byte %0d not accepted in 20 cycles, expected acceptance", k);
               k = nbytes;
            end
         end
         @(posedge CLK);
         #1;
         start = 1'b0;
      end
      rx_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 30000; i++) img[i] = 8'($urandom_range(0, 255));
      img[0] = 8'hA5;

      // Reset values
      tick();
      tick();
      check("rst_rx_ready", rx_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_data", ram_data, 0);
      RST_N = 1'b1;
      tick();
      check("idle_state", dbg_state, ST_IDLE);

      // Full image 0, unthrottled
      d0 = done_cnt;
      do_start(0);
      check("load_busy", busy, 1);
      check("load_rx_ready", rx_ready, 1);
      stream(0, 30000, 100, -1);
      check("last_rx_ready_drop", rx_ready, 0);
      check("flush_busy", busy, 1);
      repeat (4) tick();
      check("img0_done_pulses", done_cnt - d0, 1);
      check("img0_busy_after", busy, 0);
      check("img0_all_written", exp_q.size(), 0);

      // Full image 11, throttled, same bytes
      d0 = done_cnt;
      do_start(11);
      stream(11, 30000, 85, -1);
      repeat (4) tick();
      check("img11_done_pulses", done_cnt - d0, 1);
      check("img11_all_written", exp_q.size(), 0);

      // Invalid id, then a good start clears error
      do_start(12);
      check("bad_id_error", error, 1);
      check("bad_id_busy", busy, 0);
      repeat (3) tick();
      check("bad_id_error_sticky", error, 1);
      check("bad_id_still_idle", busy, 0);
      do_start(3);
      check("good_id_clears_error", error, 0);
      stream(3, 3, 100, -1);
      tick();
      check("img3_first_write", exp_q.size(), 0);
      do_abort();

      // Abort after 7 bytes of image 5
      d0 = done_cnt;
      do_start(5);
      stream(5, 7, 100, -1);
      do_abort();
      check("abort_rx_ready", rx_ready, 0);
      check("abort_busy", busy, 0);
      repeat (5) tick();
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_writes", exp_q.size(), 0);
      // Restart at phase 0; abort lands on the cycle of the second write
      do_start(5);
      stream(5, 6, 100, -1);
      do_abort();
      repeat (3) tick();
      check("restart_writes", exp_q.size(), 0);
      check("restart_no_done", done_cnt - d0, 0);

      // Start pulsed while busy on image 2 is ignored
      do_start(2);
      stream(2, 600, 100, 300);
      check("busy_start_still_busy", busy, 1);
      do_abort();
      tick();
      check("busy_start_writes", exp_q.size(), 0);

      // Asynchronous reset in the middle of a pixel
      do_start(7);
      stream(7, 4, 100, -1);
      #3;
      RST_N = 1'b0;
      #1;
      check("async_rst_ram_addr", ram_addr, 0);
      check("async_rst_ram_data", ram_data, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_rx_ready", rx_ready, 0);
      check("async_rst_ram_we", ram_we, 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      tick();
      check("post_rst_idle", busy, 0);
      do_start(7);
      stream(7, 6, 100, -1);
      tick();
      check("post_rst_writes", exp_q.size(), 0);
      do_abort();
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/image_ram_writer.md
Name: image_ram_writer

Overview:
- Writer side of the product-image memory that the screen-position-to-ROM-address path reads.
- Receives a byte stream of R,G,B bytes for one 100x100 product image and assembles it into 24-bit pixels.
- Writes each pixel into the image RAM at ImageID*10000 + y*100 + x, so the existing display path reads it back unchanged.
- Sits between the serial/host byte source and the dual-port image RAM write port.

Parameters:
- R_WIDTH, 8, red component width
- G_WIDTH, 8, green component width
- B_WIDTH, 8, blue component width
- ROM_ADDR_BUS_WIDTH, 17, image RAM address width
- PRDCT_PIC_WIDTH, 100, image width in pixels
- PRDCT_PIC_HEIGHT, 100, image height in pixels
- NUM_IMAGES, 12, number of valid product image slots (IDs 0..NUM_IMAGES-1)

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST_N  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to load an image
- image_id  in  4  target slot, sampled when start is accepted
- abort  in  1  one-cycle cancel of the load in progress
- rx_data  in  8  stream byte, order R,G,B per pixel, raster order (x fastest)
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts a byte this cycle
- ram_addr  out  ROM_ADDR_BUS_WIDTH  write address
- ram_data  out  R_WIDTH+G_WIDTH+B_WIDTH  pixel {R,G,B}, R in MSBs
- ram_we  out  1  write strobe, one cycle per pixel
- busy  out  1  load in progress
- done  out  1  one-cycle pulse after the last pixel is written
- error  out  1  sticky: last start had an invalid image_id

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; rx_ready, ram_we, busy, done, error = 0; ram_addr, ram_data = 0; byte phase = 0; pixel counter = 0.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - start with image_id < NUM_IMAGES: register base = image_id*PRDCT_PIC_WIDTH*PRDCT_PIC_HEIGHT, clear pixel counter and byte phase, clear error, go to LOAD.
  - start with image_id >= NUM_IMAGES: set error=1 and stay in IDLE; no write occurs.
- LOAD:
  - rx_ready=1 and busy=1.
  - A byte is accepted when rx_valid & rx_ready.
  - Phase 0 latches R, phase 1 latches G, phase 2 latches B; the phase wraps 2->0.
  - On the cycle after the B byte is accepted: ram_we=1, ram_data={R,G,B}, ram_addr=base+pixel counter. The pixel counter then increments.
  - Write latency is exactly 1 cycle from B acceptance.
  - Back-to-back bytes are accepted every cycle without stalls.
- Last pixel (counter = W*H-1) accepted: rx_ready drops the following cycle and the state goes to FLUSH.
- FLUSH: emits the final ram_we, then goes to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Address range: max address 11*10000+9999 = 119999, which fits 17 bits. Addresses outside base..base+9999 are never driven with ram_we=1.
- Pixel counter width is 14 bits and wraps only via a new start.
- start while busy is ignored (no re-sample of image_id).
- abort in LOAD or FLUSH:
  - Next state is IDLE, rx_ready=0, partial pixel discarded.
  - A ram_we already scheduled for the abort cycle still completes; no later writes occur.
  - done is not pulsed.
- abort and start in the same IDLE cycle: start wins.
- rx_valid while rx_ready=0: the byte is not consumed (source holds it).
- ram_we=0 implies ram_addr and ram_data hold their last values.
- RST_N asserted mid-load: immediate return to reset values; the RAM contents written so far are kept.

Decomposition:
- Shared package for the image-geometry constants also used by the display locator: PRDCT_PIC_WIDTH, PRDCT_PIC_HEIGHT, NUM_IMAGES, per-image size 10000, ROM_ADDR_BUS_WIDTH, and the state encoding.
- One sub-module, rgb_byte_packer: byte phase counter plus R/G/B holding registers. It emits pixel_valid and pixel, and is cleared on start/abort.
- The top level holds the FSM, base/counter arithmetic and RAM strobes.

Test Plan:
- start, image_id=0, then 30000 bytes with rx_valid held high:
  - exactly 10000 ram_we pulses at addresses 0..9999;
  - first write is data={b0,b1,b2} one cycle after b2;
  - done pulses once; busy then drops.
- start, image_id=11, stream with rx_valid toggling 1/0: first write at 110000, last at 119999, same data as the unthrottled run.
- start, image_id=12: error=1, no ram_we, busy stays 0. A following start with id=3 clears error and the first write is at 30000.
- abort after 7 bytes in image 5:
  - two writes at 50000 and 50001, none after;
  - no done pulse;
  - rx_ready=0 the next cycle;
  - a restart begins again at 50000 with phase 0.
- Pulse start with image_id=4 while busy loading image 2: it is ignored and all addresses stay within 20000..29999.
- RST_N low for 1 cycle mid-pixel: all outputs 0 asynchronously. After release, state is IDLE and the next load starts at its base with phase 0.
